// File: rtl/amplitude_envelope_detector.sv
// Envelope follower: half-cycle peak hold, asymmetric smoothing, Q14 normalization, hysteretic burst FSM.
// Latency: envelope_est/env_valid at E0+2, burst outputs at E0+3; no backpressure, every clk_en sample is accepted.
module amplitude_envelope_detector #(
    parameter int                      WIDTH             = 18,
    parameter int                      FRAC              = 14,
    parameter int                      ATTACK_SHIFT      = 4,
    parameter int                      RELEASE_SHIFT     = 8,
    parameter logic signed [WIDTH-1:0] GAIN              = 18'sd32768,
    parameter logic signed [WIDTH-1:0] BURST_ON          = 18'sd19661,
    parameter logic signed [WIDTH-1:0] BURST_OFF         = 18'sd17203,
    parameter logic [15:0]             MIN_BURST_UPDATES = 16'd16,
    parameter logic [15:0]             MAX_HALF_PERIOD   = 16'd1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic signed [WIDTH-1:0] sample_in,
    output logic signed [WIDTH-1:0] envelope_est,
    output logic                    env_valid,
    output logic                    burst_active,
    output logic                    burst_start,
    output logic                    burst_end,
    output logic [15:0]             burst_len
);

    localparam logic signed [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CAND  = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    logic signed [WIDTH-1:0] abs_val;
    logic signed [WIDTH-1:0] cycle_peak;
    logic signed [WIDTH-1:0] half_peak;
    logic signed [WIDTH-1:0] env_amp;
    logic signed [WIDTH-1:0] amp_next;
    logic signed [WIDTH-1:0] est_next;
    logic                    prev_sign;
    logic                    peak_valid;
    logic                    amp_valid;
    logic [15:0]             half_cnt;
    logic                    crossing;
    logic                    timeout;

    // Rectifier; the most-negative code has no positive twin, so clamp it.
    always_comb begin
        if (sample_in == NEG_MIN)
            abs_val = POS_MAX;
        else if (sample_in[WIDTH-1])
            abs_val = -sample_in;
        else
            abs_val = sample_in;
    end

    assign crossing = sample_in[WIDTH-1] != prev_sign;
    assign timeout  = half_cnt == (MAX_HALF_PERIOD - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_sign  <= 1'b0;
            cycle_peak <= '0;
            half_peak  <= '0;
            half_cnt   <= '0;
            peak_valid <= 1'b0;
        end else begin
            peak_valid <= 1'b0;
            if (clk_en) begin
                prev_sign <= sample_in[WIDTH-1];
                if (crossing || timeout) begin
                    half_peak  <= cycle_peak;
                    cycle_peak <= abs_val;
                    half_cnt   <= '0;
                    peak_valid <= 1'b1;
                end else begin
                    if (abs_val > cycle_peak)
                        cycle_peak <= abs_val;
                    half_cnt <= half_cnt + 16'd1;
                end
            end
        end
    end

    logic signed [WIDTH:0]   diff;
    logic signed [WIDTH:0]   step;
    logic signed [WIDTH+1:0] amp_sum;

    // Fast attack / slow release: the shift depends on the sign of the error.
    always_comb begin
        diff    = {half_peak[WIDTH-1], half_peak} - {env_amp[WIDTH-1], env_amp};
        step    = (!diff[WIDTH] && (diff != '0)) ? (diff >>> ATTACK_SHIFT) : (diff >>> RELEASE_SHIFT);
        amp_sum = {{2{env_amp[WIDTH-1]}}, env_amp} + {step[WIDTH], step};
        if (amp_sum[WIDTH+1])
            amp_next = '0;
        else if (amp_sum[WIDTH:WIDTH-1] != 2'b00)
            amp_next = POS_MAX;
        else
            amp_next = amp_sum[WIDTH-1:0];
    end

    logic signed [2*WIDTH-1:0] amp_wide;
    logic signed [2*WIDTH-1:0] gain_wide;
    logic signed [2*WIDTH-1:0] product;
    logic signed [2*WIDTH-1:0] scaled;

    always_comb begin
        amp_wide  = {{WIDTH{env_amp[WIDTH-1]}}, env_amp};
        gain_wide = {{WIDTH{GAIN[WIDTH-1]}}, GAIN};
        product   = amp_wide * gain_wide;
        scaled    = product >>> FRAC;
        if (scaled[2*WIDTH-1])
            est_next = '0;
        else if (|scaled[2*WIDTH-2:WIDTH-1])
            est_next = POS_MAX;
        else
            est_next = scaled[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            env_amp      <= '0;
            amp_valid    <= 1'b0;
            envelope_est <= '0;
            env_valid    <= 1'b0;
        end else begin
            amp_valid <= peak_valid;
            env_valid <= amp_valid;
            if (peak_valid)
                env_amp <= amp_next;
            if (amp_valid)
                envelope_est <= est_next;
        end
    end

    logic [1:0]  state;
    logic [15:0] cnt;
    logic [15:0] cnt_inc;
    logic        on_hit;
    logic        stay_hit;

    assign cnt_inc      = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign on_hit       = envelope_est >= BURST_ON;
    assign stay_hit     = envelope_est >= BURST_OFF;
    assign burst_active = state == ST_BURST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            burst_start <= 1'b0;
            burst_end   <= 1'b0;
            burst_len   <= '0;
        end else begin
            burst_start <= 1'b0;
            burst_end   <= 1'b0;
            if (env_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (on_hit) begin
                            cnt <= 16'd1;
                            if (MIN_BURST_UPDATES <= 16'd1) begin
                                state       <= ST_BURST;
                                burst_start <= 1'b1;
                                burst_len   <= 16'd1;
                            end else begin
                                state <= ST_CAND;
                            end
                        end
                    end
                    ST_CAND: begin
                        if (!on_hit) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt_inc;
                            if (cnt_inc >= MIN_BURST_UPDATES) begin
                                state       <= ST_BURST;
                                burst_start <= 1'b1;
                                burst_len   <= cnt_inc;
                            end
                        end
                    end
                    ST_BURST: begin
                        if (!stay_hit) begin
                            state     <= ST_IDLE;
                            burst_end <= 1'b1;
                            burst_len <= cnt;
                        end else begin
                            cnt       <= cnt_inc;
                            burst_len <= cnt_inc;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_amplitude_envelope_detector.sv
// Bench for amplitude_envelope_detector: segment table plus scoreboard of envelope/burst updates.
module tb_amplitude_envelope_detector;

    localparam int AS    = 1;
    localparam int RS    = 2;
    localparam int MINB  = 4;
    localparam int MAXH  = 16;
    localparam int GAINV = 32768;
    localparam int ONV   = 19661;
    localparam int OFFV  = 17203;
    localparam int MAXV  = 131071;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clk_en = 1'b0;
    logic signed [17:0] sample_in = '0;
    logic signed [17:0] envelope_est;
    logic               env_valid;
    logic               burst_active;
    logic               burst_start;
    logic               burst_end;
    logic [15:0]        burst_len;

    amplitude_envelope_detector #(
        .ATTACK_SHIFT     (AS),
        .RELEASE_SHIFT    (RS),
        .MIN_BURST_UPDATES(16'd4),
        .MAX_HALF_PERIOD  (16'd16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .sample_in   (sample_in),
        .envelope_est(envelope_est),
        .env_valid   (env_valid),
        .burst_active(burst_active),
        .burst_start (burst_start),
        .burst_end   (burst_end),
        .burst_len   (burst_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic start;
        logic stop;
        logic active;
        int   len;
    } burst_exp_t;

    typedef struct {
        int   amp;
        int   nhalf;
        logic exp_act;
        int   exp_est;
    } seg_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_env = 0;
    int         q_est[$];
    burst_exp_t q_burst[$];

    bit m_prev;
    int m_peak, m_half, m_cnt, m_env, m_st, m_bcnt, m_len;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 1'b0;
        m_peak = 0; m_half = 0; m_cnt = 0; m_env = 0;
        m_st = 0; m_bcnt = 0; m_len = 0;
        q_est.delete();
        q_burst.delete();
    endtask

    task automatic model_sample(input int s);
        bit         sg;
        int         a, d, step, est;
        longint     p;
        burst_exp_t b;
        sg = (s < 0);
        a  = (s == -131072) ? MAXV : ((s < 0) ? -s : s);
        if ((sg != m_prev) || (m_cnt == MAXH - 1)) begin
            m_half = m_peak;
            m_peak = a;
            m_cnt  = 0;
            d      = m_half - m_env;
            step   = (d > 0) ? (d >>> AS) : (d >>> RS);
            m_env  = m_env + step;
            if (m_env < 0) m_env = 0;
            if (m_env > MAXV) m_env = MAXV;
            p   = (longint'(m_env) * GAINV) >>> 14;
            est = (p > MAXV) ? MAXV : int'(p);
            q_est.push_back(est);
            b.start = 1'b0;
            b.stop  = 1'b0;
            if (m_st == 0) begin
                if (est >= ONV) begin
                    m_bcnt = 1;
                    if (MINB <= 1) begin m_st = 2; b.start = 1'b1; m_len = 1; end
                    else m_st = 1;
                end
            end else if (m_st == 1) begin
                if (est < ONV) m_st = 0;
                else begin
                    if (m_bcnt < 65535) m_bcnt++;
                    if (m_bcnt >= MINB) begin m_st = 2; b.start = 1'b1; m_len = m_bcnt; end
                end
            end else begin
                if (est < OFFV) begin m_st = 0; b.stop = 1'b1; m_len = m_bcnt; end
                else begin
                    if (m_bcnt < 65535) m_bcnt++;
                    m_len = m_bcnt;
                end
            end
            b.active = (m_st == 2);
            b.len    = m_len;
            q_burst.push_back(b);
        end else begin
            if (a > m_peak) m_peak = a;
            m_cnt++;
        end
        m_prev = sg;
    endtask

    // Entry/exit invariant: called at one time unit after a rising edge.
    task automatic drive(input int s, input int gap);
        clk_en    = 1'b1;
        sample_in = 18'(s);
        model_sample(s);
        @(posedge clk); #1;
        clk_en = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic half_cycle(input int amp, input bit neg);
        int v[4];
        v = '{amp / 2, amp, amp / 2, amp / 4};
        for (int i = 0; i < 4; i++)
            drive(neg ? -v[i] : v[i], int'($urandom_range(0, 1)));
    endtask

    task automatic flush(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_est"},    envelope_est, 0);
        check({tag, "_valid"},  env_valid,    0);
        check({tag, "_active"}, burst_active, 0);
        check({tag, "_start"},  burst_start,  0);
        check({tag, "_end"},    burst_end,    0);
        check({tag, "_len"},    burst_len,    0);
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Scoreboard: pop expected envelope on env_valid, burst outputs one clk later.
    initial begin
        burst_exp_t b;
        int         e;
        bit         chk;
        chk = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk = 1'b0;
                continue;
            end
            if (chk) begin
                if (q_burst.size() == 0) begin
                    check("burst_queue_underrun", 1, 0);
                end else begin
                    b = q_burst.pop_front();
                    check("burst_start",  burst_start,  b.start);
                    check("burst_end",    burst_end,    b.stop);
                    check("burst_active", burst_active, b.active);
                    check("burst_len",    burst_len,    b.len);
                end
                chk = 1'b0;
            end else begin
                check("stray_burst_pulse", {burst_start, burst_end}, 0);
            end
            if (env_valid) begin
                n_env++;
                if (q_est.size() == 0) begin
                    check("env_valid_unexpected", 1, 0);
                end else begin
                    e = q_est.pop_front();
                    check("envelope_est", envelope_est, e);
                    chk = 1'b1;
                end
            end
        end
    end

    initial begin
        seg_t segs[7];
        bit   pol;
        int   base;

        segs[0] = '{8192,  40, 1'b0, 16382};
        segs[1] = '{12288, 16, 1'b1, 24574};
        segs[2] = '{9000,  16, 1'b1, -1};
        segs[3] = '{8192,  16, 1'b0, -1};
        segs[4] = '{12288,  2, 1'b0, -1};
        segs[5] = '{6000,  10, 1'b0, -1};
        segs[6] = '{12288, 16, 1'b1, -1};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Negative first sample is a crossing that latches the empty peak.
        base = n_env;
        drive(-100, 0);
        flush(6);
        check("neg_first_env_count", n_env - base, 1);
        check("neg_first_est", envelope_est, 0);

        pol = 1'b0;
        for (int i = 0; i < 7; i++) begin
            for (int h = 0; h < segs[i].nhalf; h++) begin
                half_cycle(segs[i].amp, pol);
                pol = ~pol;
            end
            flush(6);
            check("seg_queue_drained", q_est.size() + q_burst.size(), 0);
            check("seg_burst_active", burst_active, segs[i].exp_act);
            if (segs[i].exp_est >= 0)
                check("seg_est", envelope_est, segs[i].exp_est);
        end

        // Reset while in BURST: everything clears at once, no burst_end follows.
        async_reset();
        flush(6);
        check("post_rst_active", burst_active, 0);

        // DC input only latches on the half-period timeout.
        base = n_env;
        for (int i = 0; i < 16 * 20; i++)
            drive(5000, 0);
        flush(6);
        check("dc_timeout_count", n_env - base, 20);
        check("dc_est", envelope_est, 9998);

        // Full-scale alternation: every sample crosses, estimate clamps.
        base = n_env;
        for (int i = 0; i < 40; i++)
            drive((i % 2 == 0) ? -131072 : 131071, 0);
        flush(6);
        check("sat_env_count", n_env - base, 40);
        check("sat_est", envelope_est, 131071);
        check("final_queue_drained", q_est.size() + q_burst.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
